// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential binarized NN classifier.
`default_nettype none

package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_L0   = 2'd1,
    ST_L1   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int acc_w(input int feat_bits, input int feat_cnt);
    return feat_bits + $clog2(feat_cnt) + 1;
  endfunction

  function automatic int score_w(input int hidden_cnt);
    return $clog2(hidden_cnt + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_l0_neuron.sv
// One layer-0 binarized neuron: signed +/- feature sum against a weight row, sign -> hidden bit.
`default_nettype none

module bnn_l0_neuron
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT  = 16,
  parameter int FEAT_BITS = 4
) (
  input  logic [FEAT_CNT-1:0]           row_i,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] feat_i,
  output logic                          hbit_o
);

  localparam int AW = acc_w(FEAT_BITS, FEAT_CNT);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] x;

  always_comb begin
    acc = '0;
    x   = '0;
    for (int f = 0; f < FEAT_CNT; f++) begin
      x = $signed(AW'(FEAT_BITS'(feat_i >> (f * FEAT_BITS))));
      if (((row_i >> f) & FEAT_CNT'(1)) != '0) acc = acc + x;
      else                                      acc = acc - x;
    end
  end

  // acc >= 0 is simply a clear sign bit
  assign hbit_o = ~acc[AW-1];

endmodule

`default_nettype wire

// File: rtl/bnn2_seq_hs.sv
// Two-layer binarized NN classifier, PAR hidden neurons per cycle then one class per cycle.
// Optional BNN_SCORE_OUT_EN adds a best_score output carrying the winning class score.
`default_nettype none

module bnn2_seq_hs
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT   = 16,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 10,
  parameter int PAR        = 4,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  Weights0 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]  features,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]   prediction
`ifdef BNN_SCORE_OUT_EN
  ,
  output logic [$clog2(HIDDEN_CNT+1)-1:0] best_score
`endif
);

  localparam int NL0 = ceil_div(HIDDEN_CNT, PAR);
  localparam int C0W = cnt_w(NL0);
  localparam int C1W = cnt_w(CLASS_CNT);
  localparam int SW  = score_w(HIDDEN_CNT);
  localparam int PW  = $clog2(CLASS_CNT);

  state_e                        state_q, state_d;
  logic [C0W-1:0]                batch_q, batch_d;
  logic [C1W-1:0]                cls_q, cls_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic [HIDDEN_CNT-1:0]         hid_q, hid_d;
  logic [PAR-1:0]                hbit;
  logic [HIDDEN_CNT-1:0]         row1;
  logic [SW-1:0]                 score;
  logic [SW-1:0]                 sc_q;
  logic [PW-1:0]                 sc_idx_q;
  logic                          sc_vld_q;
  logic [SW-1:0]                 best_q;
  logic [PW-1:0]                 pred_q;
  logic                          ov_q;

  for (genvar p = 0; p < PAR; p++) begin : g_neur
    logic [31:0]         hidx;
    logic [FEAT_CNT-1:0] row;
    // rows past HIDDEN_CNT shift out to zero and their bits are never stored
    assign hidx = 32'(batch_q) * 32'(PAR) + 32'(p);
    assign row  = FEAT_CNT'(Weights0 >> (hidx * 32'(FEAT_CNT)));
    bnn_l0_neuron #(
      .FEAT_CNT (FEAT_CNT),
      .FEAT_BITS(FEAT_BITS)
    ) u_neuron (
      .row_i (row),
      .feat_i(feat_q),
      .hbit_o(hbit[p])
    );
  end

  for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_hid
    assign hid_d[h] = (state_q == ST_L0 && batch_q == C0W'(h / PAR)) ? hbit[h % PAR] : hid_q[h];
  end

  assign row1  = HIDDEN_CNT'(Weights1 >> (32'(cls_q) * 32'(HIDDEN_CNT)));
  assign score = SW'($countones(~(hid_q ^ row1)));

  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    cls_d   = cls_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_L0;
      ST_L0: begin
        if (batch_q == C0W'(NL0 - 1)) begin
          state_d = ST_L1;
          batch_d = '0;
        end else begin
          batch_d = batch_q + 1'b1;
        end
      end
      ST_L1: begin
        if (cls_q == C1W'(CLASS_CNT - 1)) begin
          state_d = ST_DONE;
          cls_d   = '0;
        end else begin
          cls_d = cls_q + 1'b1;
        end
      end
      ST_DONE: if (ov_q && out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // class scores are registered and compared one cycle later; the last
  // compare lands in the first DONE cycle, together with out_valid rising
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      batch_q  <= '0;
      cls_q    <= '0;
      feat_q   <= '0;
      hid_q    <= '0;
      sc_q     <= '0;
      sc_idx_q <= '0;
      sc_vld_q <= 1'b0;
      best_q   <= '0;
      pred_q   <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      batch_q  <= batch_d;
      cls_q    <= cls_d;
      hid_q    <= hid_d;
      sc_q     <= score;
      sc_idx_q <= PW'(cls_q);
      sc_vld_q <= (state_q == ST_L1);
      if (state_q == ST_IDLE && in_valid) begin
        feat_q <= features;
        best_q <= '0;
        pred_q <= '0;
      end else if (sc_vld_q && sc_q > best_q) begin
        best_q <= sc_q;
        pred_q <= sc_idx_q;
      end
      ov_q <= (state_q == ST_DONE) && !(ov_q && out_ready);
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = ov_q;
  assign prediction = pred_q;
`ifdef BNN_SCORE_OUT_EN
  assign best_score = best_q;
`endif

endmodule

`default_nettype wire
